// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the core's single memory port between the instruction fetch unit
//   (IFU, read-only) and the load/store unit (LSU, read/write). One
//   transaction is outstanding at a time. Simultaneous requests are arbitrated
//   round-robin against the master that completed the last handshake.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   ifu_req_*/ifu_addr    IFU read request channel (valid/ready)
//   ifu_resp_*/ifu_rdata  IFU read response channel (valid/ready)
//   lsu_req_*/lsu_addr,
//   lsu_wen/wdata/wmask   LSU read/write request channel (valid/ready)
//   lsu_resp_*/lsu_rdata  LSU response channel: read data or write ack
//   mem_req_*/mem_addr,
//   mem_wen/wdata/wmask   request channel toward the memory slave
//   mem_resp_*/mem_rdata  response channel from the memory slave
//   grant                 current owner: 00 none, 01 IFU, 10 LSU
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Owner encoding: 0 = IFU, 1 = LSU.
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [1:0]  grant_q, grant_d;

  logic        owner_req_valid;
  logic        owner_resp_ready;
  logic        pick_lsu;

  assign owner_req_valid  = (owner_q == OWNER_LSU) ? lsu_req_valid  : ifu_req_valid;
  assign owner_resp_ready = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

  // LSU wins when it is the only requester, or on a tie when the IFU owned
  // the previous transaction. last_owner resets to IFU so the first tie
  // after reset goes to the LSU.
  assign pick_lsu = lsu_req_valid && (!ifu_req_valid || (last_owner_q == OWNER_IFU));

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;

    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (ifu_req_valid || lsu_req_valid) begin
          owner_d = pick_lsu ? OWNER_LSU : OWNER_IFU;
          grant_d = pick_lsu ? 2'b10 : 2'b01;
          state_d = REQ;
        end
      end

      REQ: begin
        // An owner that withdraws before the handshake simply loses the
        // grant; last_owner is only updated by a completed handshake.
        if (!owner_req_valid) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (mem_req_ready) begin
          state_d      = RESP;
          last_owner_d = owner_q;
        end
      end

      RESP: begin
        if (mem_resp_valid && owner_resp_ready) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IFU;
      last_owner_q <= OWNER_IFU;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
    end
  end

  assign grant = grant_q;

  // Channel steering. Everything is decoded from registered state, so in
  // IDLE (including while reset is held) every valid/ready/data output is 0.
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    mem_resp_ready = 1'b0;

    case (state_q)
      REQ: begin
        mem_req_valid = owner_req_valid;
        if (owner_q == OWNER_LSU) begin
          mem_addr      = lsu_addr;
          mem_wen       = lsu_wen;
          mem_wdata     = lsu_wdata;
          mem_wmask     = lsu_wmask;
          lsu_req_ready = mem_req_ready;
        end else begin
          mem_addr      = ifu_addr;
          ifu_req_ready = mem_req_ready;
        end
      end

      RESP: begin
        mem_resp_ready = owner_resp_ready;
        if (owner_q == OWNER_LSU) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = mem_rdata;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = mem_rdata;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU and the memory slave.
- Uses a 3-state FSM with a valid/ready request channel and a valid/ready response channel.
- Allows one transaction outstanding at a time; round-robin on contention.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
ifu_req_valid  in  1  IFU read request valid
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  IFU read data valid
ifu_resp_ready  in  1  IFU accepts response
ifu_rdata  out  DATA_W  IFU read data
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DATA_W  LSU write data
lsu_wmask  in  DATA_W/8  byte write enables
lsu_resp_valid  out  1  LSU response valid (read data or write ack)
lsu_resp_ready  in  1  LSU accepts response
lsu_rdata  out  DATA_W  LSU read data
mem_req_valid  out  1  request to memory valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  forwarded address
mem_wen  out  1  forwarded write enable
mem_wdata  out  DATA_W  forwarded write data
mem_wmask  out  DATA_W/8  forwarded byte mask
mem_resp_valid  in  1  memory response valid
mem_resp_ready  out  1  arbiter accepts memory response
mem_rdata  in  DATA_W  memory read data
grant  out  2  current owner: 00 none, 01 IFU, 10 LSU

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, grant=00, last_owner=IFU.
  - All valid/ready outputs are 0; all data/addr/mask outputs are 0.
  - Reset mid-transaction abandons it. There is no replay; the memory side must also be reset.
- IDLE:
  - No valid/ready is asserted.
  - If only one master's req_valid=1, grant it.
  - If both are valid, grant the master that is not last_owner. The first tie after reset goes to the LSU.
  - On grant, register the owner and go to REQ next cycle. Minimum request-to-mem_req_valid latency is 1 cycle.
- REQ:
  - mem_req_valid = owner's req_valid.
  - mem_addr/mem_wen/mem_wdata/mem_wmask are driven combinationally from the owner's inputs. When the owner is IFU: wen=0, wdata=0, wmask=0.
  - Owner's req_ready = mem_req_ready. Non-owner req_ready=0.
  - On mem_req_valid & mem_req_ready: go to RESP and set last_owner=owner.
  - If the owner drops req_valid before the handshake (protocol violation), return to IDLE and grant=00.
- RESP:
  - Owner's resp_valid = mem_resp_valid.
  - Owner's rdata = mem_rdata. Non-owner rdata=0 and resp_valid=0.
  - mem_resp_ready = owner's resp_ready.
  - On mem_resp_valid & owner resp_ready: go to IDLE next cycle. New arbitration happens in that IDLE cycle, so back-to-back transactions carry a 1-cycle bubble.
- grant reflects the registered owner in REQ/RESP and is 00 in IDLE.
- Non-owner requests stay pending with req_ready=0. Masters must hold request fields stable until the handshake.
- A request arriving while another transaction is in REQ/RESP is not granted until the next IDLE.
- Round-robin bounds starvation: each master waits at most one foreign transaction under continuous contention.

Test Plan:
- Single IFU read:
  - Stimulus: ifu_req_valid=1, ifu_addr=0x80000000; mem_req_ready=1; mem_resp_valid=1 with mem_rdata=0x00000413 two cycles later; ifu_resp_ready=1.
  - Required: grant=01; mem_addr=0x80000000, mem_wen=0; ifu_resp_valid pulses with rdata 0x00000413; back in IDLE after the handshake.
- LSU write:
  - Stimulus: lsu_wen=1, lsu_addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF.
  - Required: mem_* mirror these values while grant=10; lsu_resp_valid follows mem_resp_valid; ifu_req_ready=0 throughout.
- Contention:
  - Stimulus: IFU and LSU both valid in the same cycle right after reset, 4 back-to-back transactions.
  - Required: grant order LSU, IFU, LSU, IFU; 1 IDLE bubble between each.
- Backpressure:
  - Stimulus: mem_req_ready=0 for 3 cycles, then mem_resp_valid=1 with owner resp_ready=0 for 2 cycles.
  - Required: mem_req_valid held with stable fields; response is held, not dropped; state leaves RESP only on the joint handshake.
- Reset mid-RESP:
  - Stimulus: assert rst_n=0 asynchronously between clock edges.
  - Required: all valid/ready outputs 0 and grant=00 immediately, without waiting for a clock edge; after release, first tie goes to LSU.
- Owner withdraws:
  - Stimulus: LSU drops lsu_req_valid in REQ before mem_req_ready.
  - Required: return to IDLE, grant=00; a pending IFU request is granted the following cycle.
